mult_digit_serial: RTL and testbench
====================================

# mult_digit_serial

Parametrised iterative multiplier: WIDTH x WIDTH operands multiplied DIGIT x DIGIT bits per cycle, 2*WIDTH-bit product. Generalises the team's fixed 4x4 two-bit-digit datapath/controller pair into one self-sequenced block with its own FSM, start/busy/done handshake and optional two's-complement mode. Sits between operand registers and a consumer that waits on `done`.

## Interface
- `WIDTH`, 8: operand width; must be a multiple of `DIGIT`, at least `2*DIGIT`.
- `DIGIT`, 2: digit width of the combinational partial multiplier.
- Derived: `K = WIDTH/DIGIT` digits per operand.
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-low.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  WIDTH  multiplicand; captured on accepted start.
- `b`  in  WIDTH  multiplier; captured on accepted start.
- `busy`  out  1  high from the cycle after accepted start until `done` drops.
- `done`  out  1  one-cycle pulse; `product` valid from this cycle on.
- `product`  out  2*WIDTH  result; held until the next `done`.

## Operation
- Registers: `a_r`, `b_r` (WIDTH), digit indices `i`, `j` (each ceil(log2 K) bits), accumulator `acc` (2*WIDTH), `product` (2*WIDTH).
- FSM states: IDLE, CALC, DONE (plus FIX when `MULT_SIGNED_EN` defined).
- IDLE: `start`=1 -> load `a_r`, `b_r`; clear `acc`, `i`, `j`; go to CALC. `start`=0 -> stay.
- CALC, each cycle: `acc <= acc + (zero_ext(a_r digit i * b_r digit j) << DIGIT*(i+j))`. Digit product is 2*DIGIT bits, zero-extended to 2*WIDTH; no overflow is possible. `j` increments; on `j`=K-1 it wraps to 0 and `i` increments. After step (`i`,`j`)=(K-1,K-1) -> DONE (or FIX).
- DONE: `product <= acc` at the transition into DONE, so `product` is valid while `done`=1; `done`=1 for exactly one cycle; go to IDLE.
- `start` in CALC/FIX/DONE is ignored; operands are not recaptured.
- `a`, `b` may change freely after the accepting edge.
- Zero operands are not short-circuited; latency is data-independent.

## Timing
- Reset values: `busy`=0, `done`=0, `product`=0, state IDLE, `acc`=0, `i`=`j`=0.
- Reset assertion mid-operation aborts immediately; `product` returns to 0; no `done` pulse.
- Start accepted at edge 0 -> CALC for K*K cycles -> `done` high in cycle K*K+1 (unsigned). WIDTH=8, DIGIT=2: `done` in cycle 17.
- `busy` high cycles 1..K*K+1 (inclusive of `done` cycle), low in IDLE.
- Back-to-back: `start` held high during the `done` cycle is not accepted (state is DONE); accepted on the following IDLE cycle. Minimum issue interval K*K+2 cycles.

## Configuration
- `MULT_SIGNED_EN` defined: `a`, `b`, `product` are two's complement. On accepted start, `a_r`/`b_r` load magnitudes (|-2^(WIDTH-1)| representable as unsigned WIDTH bits) and sign `a[WIDTH-1]^b[WIDTH-1]` is registered. CALC unchanged. Extra FIX state, one cycle: `acc` negated if sign=1, then DONE. Latency K*K+2; minimum interval K*K+3.
- Undefined: operands unsigned, no FIX state, latency K*K+1.

## Test plan
- WIDTH=8, DIGIT=2, unsigned: a=255, b=255, start at cycle 0 -> `done` in cycle 17, `product`=0xFE01, `busy` high cycles 1-17.
- a=0, b=0xA5 -> `product`=0x0000 after the same 17-cycle latency; then a=0x0C, b=0x0D -> 0x009C, previous product held until the new `done`.
- Start pulsed again at cycle 5 with a=1, b=1 -> ignored; result is first operands; exactly one `done`.
- Reset low at cycle 8 of a 255x255 run -> `busy`, `done`, `product` 0 immediately; new start after release gives correct result with full latency.
- WIDTH=4, DIGIT=2: a=15, b=13 -> `product`=195 (0xC3), `done` in cycle 5.
- `MULT_SIGNED_EN`, WIDTH=8: -128 x -128 -> 0x4000; -1 x 127 -> 0xFF81; each `done` in cycle 18.

Source files
------------

// File: rtl/mult_digit_serial.sv
// Iterative WIDTH x WIDTH multiplier: one DIGIT x DIGIT partial product per cycle, start/busy/done handshake.
// Define MULT_SIGNED_EN for two's-complement operands and product (adds a one-cycle FIX state).
module mult_digit_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
);
    localparam int K  = WIDTH / DIGIT;
    localparam int IW = (K > 1) ? $clog2(K) : 1;
    localparam int PW = 2 * WIDTH;
    localparam logic [IW-1:0] LAST = IW'(K - 1);

    // state  | meaning
    // S_IDLE | waiting for start, operands captured on accept
    // S_CALC | one digit-pair product accumulated per cycle
    // S_FIX  | signed build only: negate accumulator when signs differ
    // S_DONE | one-cycle done pulse, product valid
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_r_q, a_r_d, b_r_q, b_r_d;
    logic [IW-1:0]      i_q, i_d, j_q, j_d;
    logic [PW-1:0]      acc_q, acc_d, product_q, product_d;
    logic [DIGIT-1:0]   a_dig, b_dig;
    logic [2*DIGIT-1:0] pp;
    logic [PW-1:0]      pp_sh;
`ifdef MULT_SIGNED_EN
    logic               sign_q, sign_d;
`endif

    assign a_dig = DIGIT'(a_r_q >> (DIGIT * int'(i_q)));
    assign b_dig = DIGIT'(b_r_q >> (DIGIT * int'(j_q)));
    assign pp    = (2*DIGIT)'(a_dig) * (2*DIGIT)'(b_dig);
    assign pp_sh = PW'(pp) << (DIGIT * (int'(i_q) + int'(j_q)));

    always_comb begin
        state_d   = state_q;
        a_r_d     = a_r_q;
        b_r_d     = b_r_q;
        i_d       = i_q;
        j_d       = j_q;
        acc_d     = acc_q;
        product_d = product_q;
`ifdef MULT_SIGNED_EN
        sign_d    = sign_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
`ifdef MULT_SIGNED_EN
                    // magnitude of -2^(WIDTH-1) still fits as an unsigned WIDTH-bit value
                    a_r_d  = a_i[WIDTH-1] ? -a_i : a_i;
                    b_r_d  = b_i[WIDTH-1] ? -b_i : b_i;
                    sign_d = a_i[WIDTH-1] ^ b_i[WIDTH-1];
`else
                    a_r_d  = a_i;
                    b_r_d  = b_i;
`endif
                    i_d     = '0;
                    j_d     = '0;
                    acc_d   = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                acc_d = acc_q + pp_sh;
                j_d   = (j_q == LAST) ? '0 : j_q + IW'(1);
                if (j_q == LAST) begin
                    i_d = (i_q == LAST) ? '0 : i_q + IW'(1);
                end
                if (i_q == LAST && j_q == LAST) begin
`ifdef MULT_SIGNED_EN
                    state_d = S_FIX;
`else
                    product_d = acc_d;
                    state_d   = S_DONE;
`endif
                end
            end
`ifdef MULT_SIGNED_EN
            S_FIX: begin
                acc_d     = sign_q ? -acc_q : acc_q;
                product_d = acc_d;
                state_d   = S_DONE;
            end
`endif
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            a_r_q     <= '0;
            b_r_q     <= '0;
            i_q       <= '0;
            j_q       <= '0;
            acc_q     <= '0;
            product_q <= '0;
`ifdef MULT_SIGNED_EN
            sign_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            a_r_q     <= a_r_d;
            b_r_q     <= b_r_d;
            i_q       <= i_d;
            j_q       <= j_d;
            acc_q     <= acc_d;
            product_q <= product_d;
`ifdef MULT_SIGNED_EN
            sign_q    <= sign_d;
`endif
        end
    end

    assign busy_o    = (state_q != S_IDLE);
    assign done_o    = (state_q == S_DONE);
    assign product_o = product_q;

endmodule

// File: tb/tb_mult_digit_serial.sv
// Bench for mult_digit_serial: operation-level model checked every cycle, plus directed literal checks.
module tb_mult_digit_serial;
    localparam int W = 8;
`ifdef MULT_SIGNED_EN
    localparam int          LAT    = 18;
    localparam int          LAT4   = 6;
    localparam logic [15:0] EXP_FF = 16'h0001;
    localparam logic [7:0]  EXP4   = 8'h03;
`else
    localparam int          LAT    = 17;
    localparam int          LAT4   = 5;
    localparam logic [15:0] EXP_FF = 16'hFE01;
    localparam logic [7:0]  EXP4   = 8'hC3;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  a = '0, b = '0;
    logic          busy, done;
    logic [2*W-1:0] prod;
    logic          start4 = 1'b0;
    logic [3:0]    a4 = '0, b4 = '0;
    logic          busy4, done4;
    logic [7:0]    prod4;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    bit             pend = 1'b0;
    int             e_acc = 0;
    logic [15:0]    pend_prod = '0;
    logic [15:0]    held = '0;
    logic           exp_busy, exp_done;

    mult_digit_serial #(.WIDTH(W), .DIGIT(2)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .a_i(a), .b_i(b),
        .busy_o(busy), .done_o(done), .product_o(prod)
    );

    mult_digit_serial #(.WIDTH(4), .DIGIT(2)) u_dut4 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start4), .a_i(a4), .b_i(b4),
        .busy_o(busy4), .done_o(done4), .product_o(prod4)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model_mul(input logic [7:0] x, input logic [7:0] y);
`ifdef MULT_SIGNED_EN
        return 16'(longint'($signed(x)) * longint'($signed(y)));
`else
        return 16'(longint'(x) * longint'(y));
`endif
    endfunction

    task automatic check(input string name, input longint act, input longint expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // operation-level model: an accepted op is busy for LAT cycles, done in the last
    always @(posedge clk) begin
        bit was;
        cyc++;
        if (!rst_n) begin
            pend = 1'b0;
            held = '0;
        end else begin
            was = pend;
            if (pend && cyc == e_acc + LAT + 1) pend = 1'b0;
            if (!was && start) begin
                pend      = 1'b1;
                e_acc     = cyc - 1;
                pend_prod = model_mul(a, b);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            pend     = 1'b0;
            held     = '0;
            exp_busy = 1'b0;
            exp_done = 1'b0;
        end else begin
            exp_done = pend && (cyc == e_acc + LAT);
            if (exp_done) held = pend_prod;
            exp_busy = pend;
        end
        tests++;
        if (busy !== exp_busy || done !== exp_done || prod !== held) begin
            fails++;
            $display("FAIL cycle %0d: busy %b exp %b, done %b exp %b, product 0x%0h exp 0x%0h",
                     cyc, busy, exp_busy, done, exp_done, prod, held);
        end
    end

    task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic [15:0] expp,
                          input bit poke, input string name);
        int e, nd, lat;
        logic [15:0] p;
        nd = 0; lat = -1; p = 'x;
        @(negedge clk); #1;
        start = 1'b1; a = x; b = y;
        @(posedge clk); #1;
        e = cyc - 1;
        start = 1'b0; a = 8'($urandom); b = 8'($urandom);
        for (int k = 1; k <= LAT + 4; k++) begin
            @(negedge clk);
            if (done) begin nd++; lat = cyc - e; p = prod; end
            #1;
            if (poke && k == 4) begin start = 1'b1; a = 8'd1; b = 8'd1; end
            if (poke && k == 5) start = 1'b0;
        end
        check({name, " done count"}, nd, 1);
        check({name, " latency"}, lat, LAT);
        check({name, " product"}, p, expp);
    endtask

    function automatic logic [7:0] pick();
        case ($urandom_range(0, 5))
            0: return 8'h00;
            1: return 8'hFF;
            2: return 8'h80;
            3: return 8'h7F;
            4: return 8'h01;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        int e, nd, lat;
        logic [7:0] p4;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

`ifdef MULT_SIGNED_EN
        run_op(8'h80, 8'h80, 16'h4000, 1'b0, "neg128xneg128");
        run_op(8'hFF, 8'h7F, 16'hFF81, 1'b0, "neg1x127");
`else
        run_op(8'hFF, 8'hFF, 16'hFE01, 1'b0, "255x255");
`endif
        run_op(8'h00, 8'hA5, 16'h0000, 1'b0, "0xA5");
        run_op(8'h0C, 8'h0D, 16'h009C, 1'b1, "0Cx0D ignored start");

        // abort mid-operation with reset
        @(negedge clk); #1;
        start = 1'b1; a = 8'hFF; b = 8'hFF;
        @(posedge clk); #1;
        e = cyc - 1;
        start = 1'b0;
        while (cyc < e + 8) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset product", prod, 0);
        @(negedge clk); #1 rst_n = 1'b1;
        run_op(8'hFF, 8'hFF, EXP_FF, 1'b0, "after reset");

        repeat (1200) begin
            @(negedge clk); #1;
            start = ($urandom_range(0, 3) == 0);
            a = pick();
            b = pick();
        end
        start = 1'b0;
        repeat (LAT + 3) @(negedge clk);

        // narrow instance: 4x4 with two-bit digits
        nd = 0; lat = -1; p4 = 'x;
        @(negedge clk); #1;
        start4 = 1'b1; a4 = 4'd15; b4 = 4'd13;
        @(posedge clk); #1;
        e = cyc - 1;
        start4 = 1'b0; a4 = 4'd0; b4 = 4'd0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) check("w4 busy", busy4, 1);
            if (done4) begin nd++; lat = cyc - e; p4 = prod4; end
        end
        check("w4 done count", nd, 1);
        check("w4 latency", lat, LAT4);
        check("w4 product", p4, EXP4);
        check("w4 idle busy", busy4, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
